// File: rtl/decodificador_binario_decimal.sv
// decodificador_binario_decimal: registered 4-bit code to common-cathode 7-segment driver with lamp test and blanking
module decodificador_binario_decimal #(
  parameter bit BLANK_INVALID = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic       en,
  input  logic       lt,
  input  logic       bi,
  output logic [6:0] S,
  output logic       err
);
  logic [6:0] glyph;
  logic [6:0] seg_next;
  logic       invalid;
  // segment order a..g maps to S[6..0]
  always_comb begin
    glyph = 7'h00;
    case (A)
      4'h0: glyph = 7'h7E;
      4'h1: glyph = 7'h30;
      4'h2: glyph = 7'h6D;
      4'h3: glyph = 7'h79;
      4'h4: glyph = 7'h33;
      4'h5: glyph = 7'h5B;
      4'h6: glyph = 7'h5F;
      4'h7: glyph = 7'h70;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h7B;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h1F;
      4'hC: glyph = 7'h4E;
      4'hD: glyph = 7'h3D;
      4'hE: glyph = 7'h4F;
      default: glyph = 7'h47;
    endcase
  end
  assign invalid  = A > 4'd9;
  assign seg_next = bi ? 7'h00 : lt ? 7'h7F : (invalid && BLANK_INVALID) ? 7'h00 : glyph;
  always_ff @(posedge clk) begin
    if (rst) begin
      S   <= 7'h00;
      err <= 1'b0;
    end else if (en) begin
      S   <= seg_next;
      err <= invalid;
    end
  end
endmodule

// File: tb/tb_decodificador_binario_decimal.sv
// tb_decodificador_binario_decimal: scoreboard bench covering both BLANK_INVALID settings
module tb_decodificador_binario_decimal;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] A = 4'd0;
  logic       en = 1'b0;
  logic       lt = 1'b0;
  logic       bi = 1'b0;
  logic [6:0] s_blank, s_hex;
  logic       err_blank, err_hex;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] s1;
    logic       e1;
    logic [6:0] s0;
    logic       e0;
    string      tag;
  } exp_t;
  exp_t q[$];

  logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [6:0] m_s1 = 7'h00, m_s0 = 7'h00;
  logic       m_e1 = 1'b0, m_e0 = 1'b0;

  decodificador_binario_decimal #(.BLANK_INVALID(1'b1)) dut_blank (
    .clk(clk), .rst(rst), .A(A), .en(en), .lt(lt), .bi(bi), .S(s_blank), .err(err_blank));
  decodificador_binario_decimal #(.BLANK_INVALID(1'b0)) dut_hex (
    .clk(clk), .rst(rst), .A(A), .en(en), .lt(lt), .bi(bi), .S(s_hex), .err(err_hex));

  always #50 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic l, input logic b,
                      input logic [3:0] a, input string tag);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; lt = l; bi = b; A = a;
    if (r) begin
      m_s1 = 7'h00; m_e1 = 1'b0; m_s0 = 7'h00; m_e0 = 1'b0;
    end else if (e) begin
      m_e1 = (a >= 10);
      m_e0 = (a >= 10);
      m_s1 = b ? 7'h00 : l ? 7'h7F : (a >= 10) ? 7'h00 : glyph_tab[a];
      m_s0 = b ? 7'h00 : l ? 7'h7F : glyph_tab[a];
    end
    x.s1 = m_s1; x.e1 = m_e1; x.s0 = m_s0; x.e0 = m_e0; x.tag = tag;
    q.push_back(x);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks += 4;
        if (s_blank !== x.s1) begin
          errors++;
          $display("FAIL %s S(blank) got %h expected %h", x.tag, s_blank, x.s1);
        end
        if (err_blank !== x.e1) begin
          errors++;
          $display("FAIL %s err(blank) got %b expected %b", x.tag, err_blank, x.e1);
        end
        if (s_hex !== x.s0) begin
          errors++;
          $display("FAIL %s S(hex) got %h expected %h", x.tag, s_hex, x.s0);
        end
        if (err_hex !== x.e0) begin
          errors++;
          $display("FAIL %s err(hex) got %b expected %b", x.tag, err_hex, x.e0);
        end
      end
    end
  end

  initial begin
    step(1, 1, 1, 0, 4'd8, "reset");
    step(1, 0, 0, 0, 4'd0, "reset_hold");
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 4'(i), "decode");
    step(0, 1, 1, 0, 4'd5, "lamp_test");
    step(0, 1, 1, 1, 4'd5, "blank_over_lt");
    step(0, 1, 0, 0, 4'd5, "release_5");
    step(0, 1, 0, 0, 4'd3, "load_3");
    step(0, 0, 1, 0, 4'd8, "hold_lt");
    step(0, 0, 0, 1, 4'd8, "hold_bi");
    step(0, 0, 0, 0, 4'd12, "hold_a");
    step(0, 1, 0, 0, 4'd8, "load_8");
    step(1, 1, 0, 0, 4'd8, "mid_reset");
    step(0, 1, 0, 0, 4'd2, "after_reset");
    step(0, 1, 0, 1, 4'd13, "bi_err");
    step(0, 1, 1, 0, 4'd11, "lt_err");
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)), "random");
    @(negedge clk);
    en = 1'b0; rst = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
